// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode seven-segment scanner with double-buffered frame data
// and a blanking gap between digits. Optional LEADING_ZERO_BLANK_EN suppresses leading zeros.
module seven_segment_scanner #(
  parameter int DIGITS       = 4,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   DATA,
  input  logic [DIGITS-1:0]     DP,
  output logic [DIGITS-1:0]     AN,
  output logic [6:0]            SEG,
  output logic                  DPO,
  output logic [2:0]            IDX,
  output logic                  ERR
);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES - 1);
  localparam logic [2:0] LAST_IDX   = 3'(DIGITS - 1);
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif

  state_t                  state_q, state_n;
  logic [7:0]              cnt_q, cnt_n;
  logic [2:0]              idx_q, idx_n;
  logic                    err_q, err_n;
  logic                    xfer;
  logic [DIGITS-1:0][3:0]  data_w;
  logic [DIGITS-1:0][3:0]  pend_q, pend_n, disp_q, disp_n;
  logic [DIGITS-1:0]       pdp_q, pdp_n, ddp_q, ddp_n;
  logic [DIGITS-1:0][6:0]  glyph;
  logic [DIGITS-1:0]       zero_from, suppress;
  logic [DIGITS-1:0]       an_n;
  logic [6:0]              seg_n;
  logic                    dpo_n;
  logic                    zacc;

  assign data_w = DATA;
  assign IDX    = idx_q;
  assign ERR    = err_q;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  // zero_from[i]: display nibble i and every nibble above it are zero
  always_comb begin
    zero_from = '0;
    zacc      = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zacc         = zacc & (disp_q[i] == 4'h0);
      zero_from[i] = zacc;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_lane
    localparam bit CAN_BLANK = LZB_EN && (i != 0);
    assign glyph[i]    = hex_glyph(disp_q[i]);
    assign suppress[i] = CAN_BLANK & zero_from[i] & ~ddp_q[i];
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    err_n   = err_q;
    xfer    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CE) begin
          state_n = S_BLANK;
          cnt_n   = BLANK_LOAD;
          idx_n   = 3'd0;
          xfer    = 1'b1;
        end
      end
      S_BLANK: begin
        if (CE) err_n = 1'b1;  // strobe during the gap is dropped
        if (cnt_q == 8'd0) state_n = S_DRIVE;
        else               cnt_n   = cnt_q - 8'd1;
      end
      S_DRIVE: begin
        if (CE) begin
          state_n = S_BLANK;
          cnt_n   = BLANK_LOAD;
          if (idx_q == LAST_IDX) begin
            idx_n = 3'd0;
            xfer  = 1'b1;
          end else begin
            idx_n = idx_q + 3'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // A LOAD coinciding with a transfer goes straight through to display
  always_comb begin
    pend_n = LOAD ? data_w : pend_q;
    pdp_n  = LOAD ? DP     : pdp_q;
    disp_n = xfer ? pend_n : disp_q;
    ddp_n  = xfer ? pdp_n  : ddp_q;
  end

  // Display contents and idx are stable whenever the next state is DRIVE
  always_comb begin
    an_n  = '1;
    seg_n = 7'h7F;
    dpo_n = 1'b1;
    if (state_n == S_DRIVE) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_q == 3'(i) && !suppress[i]) begin
          an_n[i] = 1'b0;
          seg_n   = glyph[i];
          dpo_n   = ~ddp_q[i];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      err_q   <= 1'b0;
      pend_q  <= '0;
      pdp_q   <= '0;
      disp_q  <= '0;
      ddp_q   <= '0;
      AN      <= '1;
      SEG     <= 7'h7F;
      DPO     <= 1'b1;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      err_q   <= err_n;
      pend_q  <= pend_n;
      pdp_q   <= pdp_n;
      disp_q  <= disp_n;
      ddp_q   <= ddp_n;
      AN      <= an_n;
      SEG     <= seg_n;
      DPO     <= dpo_n;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench: each stimulus edge pushes the expected outputs from a behavioural
// model; a negedge monitor pops and compares.
module tb_seven_segment_scanner;
  localparam int D = 4;
  localparam int B = 8;

  logic          CLK = 1'b0;
  logic          RST, CE, LOAD;
  logic [15:0]   DATA;
  logic [3:0]    DP;
  logic [3:0]    AN;
  logic [6:0]    SEG;
  logic          DPO;
  logic [2:0]    IDX;
  logic          ERR;

  seven_segment_scanner #(.DIGITS(D), .BLANK_CYCLES(B)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .LOAD(LOAD), .DATA(DATA), .DP(DP),
    .AN(AN), .SEG(SEG), .DPO(DPO), .IDX(IDX), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         at;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dpo;
    logic [2:0] idx;
    logic       err;
    bit         c_seg;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // behavioural model state
  bit          m_idle = 1'b1;
  int          m_idx = 0;
  int          m_drive_edge = 0;
  bit          m_err = 1'b0;
  logic [15:0] m_pend = '0, m_disp = '0;
  logic [3:0]  m_pdp = '0, m_ddp = '0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, act, req);
    end
  endtask

  task automatic step(input bit rst, input bit ce, input bit ld,
                      input logic [15:0] d, input logic [3:0] p);
    exp_t x;
    bit   acc, xfer, sup;
    RST = rst; CE = ce; LOAD = ld; DATA = d; DP = p;
    @(posedge CLK);
    cyc++;
    if (rst) begin
      m_idle = 1'b1; m_idx = 0; m_err = 1'b0;
      m_pend = '0; m_pdp = '0; m_disp = '0; m_ddp = '0;
    end else begin
      acc  = ce && (m_idle || cyc > m_drive_edge);
      xfer = 1'b0;
      if (ce && !acc) m_err = 1'b1;
      if (acc) begin
        if (m_idle) begin
          m_idx = 0;
          xfer  = 1'b1;
        end else begin
          if (m_idx == D - 1) xfer = 1'b1;
          m_idx = (m_idx + 1) % D;
        end
        m_idle       = 1'b0;
        m_drive_edge = cyc + B;
      end
      if (ld) begin m_pend = d; m_pdp = p; end
      if (xfer) begin m_disp = m_pend; m_ddp = m_pdp; end
    end
    x.at = cyc; x.idx = 3'(m_idx); x.err = m_err;
    x.an = '1; x.seg = 7'h7F; x.dpo = 1'b1; x.c_seg = 1'b1;
    if (!m_idle && cyc >= m_drive_edge) begin
`ifdef LEADING_ZERO_BLANK_EN
      sup = (m_idx != 0) && ((m_disp >> (4 * m_idx)) == 16'h0) && !m_ddp[m_idx];
`else
      sup = 1'b0;
`endif
      if (sup) x.c_seg = 1'b0;
      else begin
        x.an[m_idx] = 1'b0;
        x.seg       = glyph_tab[m_disp[4*m_idx +: 4]];
        x.dpo       = ~m_ddp[m_idx];
      end
    end
    sb.push_back(x);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic scan(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
      idle(gap);
    end
  endtask

  always @(negedge CLK) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("sync", 32'(cyc), 32'(x.at));
      chk("an", 32'(AN), 32'(x.an));
      if (x.c_seg) begin
        chk("seg", 32'(SEG), 32'(x.seg));
        chk("dpo", 32'(DPO), 32'(x.dpo));
      end
      chk("idx", 32'(IDX), 32'(x.idx));
      chk("err", 32'(ERR), 32'(x.err));
    end
  end

  initial begin
    RST = 1'b1; CE = 1'b0; LOAD = 1'b0; DATA = '0; DP = '0;
    step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    // reset then slow strobes
    idle(5);
    scan(5, 99);
    // decode pattern, visible after the next wrap
    step(1'b0, 1'b0, 1'b1, 16'h5A10, 4'b0100);
    scan(8, 20);
    // tear-free update across the wrap
    while (m_idx != 1) scan(1, 20);
    scan(1, 20);
    step(1'b0, 1'b0, 1'b1, 16'h1111, 4'h0);
    idle(15);
    scan(1, 20);
    step(1'b0, 1'b1, 1'b1, 16'h2222, 4'h0);
    idle(20);
    scan(3, 20);
    // overrun: second strobe inside the gap
    step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    idle(20);
    // reset during the gap
    step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    idle(5);
    // leading-zero pattern
    step(1'b0, 1'b0, 1'b1, 16'h0070, 4'h0);
    scan(8, 20);
    // reset and strobe together: reset wins
    step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    idle(3);
    // random traffic
    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 599) == 0, $urandom_range(0, 10) == 0,
           $urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom));
    idle(12);
    @(negedge CLK);
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
